keypad_path: RTL and testbench

//  Input-side peripheral and counterpart of the 7-seg display path: scans a 4x4 matrix keypad, debounces,

---
 rtl/keypad_path.sv | 179 +++++++++++++++++
 tb/tb_keypad_path.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_path.sv
// 4x4 matrix keypad scanner: column drive, row synchronizer, debounce FSM and
// a CPU-readable {valid, overrun, key} status word acknowledged by a read strobe.
module keypad_path #(
    parameter int SCAN_MOD = 10000,
    parameter int DEBOUNCE = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  in_row,
    output logic [3:0]  out_col,
    input  logic        re,
    output logic [15:0] rd_data
);

    localparam int TW = $clog2(SCAN_MOD);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_MOD - 1);
    localparam logic [CW-1:0] DEB_MAX   = CW'(DEBOUNCE);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2
    } state_t;

    state_t          r_state;
    logic [TW-1:0]   r_tick_cnt;
    logic [3:0]      r_row_m;
    logic [3:0]      r_row_s;
    logic [1:0]      r_col;
    logic [3:0]      r_out_col;
    logic [CW-1:0]   r_cnt;
    logic [3:0]      r_pat;
    logic [1:0]      r_row_idx;
    logic            r_valid;
    logic            r_overrun;
    logic [3:0]      r_key;

    state_t          w_state_nx;
    logic [1:0]      w_col_nx;
    logic [CW-1:0]   w_cnt_nx;
    logic [CW-1:0]   w_cnt_inc;
    logic [3:0]      w_pat_nx;
    logic [1:0]      w_idx_nx;
    logic            w_latch;
    logic            w_tick;

    // A press is only accepted when exactly one row line is pulled low.
    function automatic logic one_cold(input logic [3:0] v);
        case (v)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: one_cold = 1'b1;
            default:                             one_cold = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] row_index(input logic [3:0] v);
        case (v)
            4'b1101: row_index = 2'd1;
            4'b1011: row_index = 2'd2;
            4'b0111: row_index = 2'd3;
            default: row_index = 2'd0;
        endcase
    endfunction

    assign w_tick    = (r_tick_cnt == TICK_LAST);
    assign w_cnt_inc = r_cnt + CNT_ONE;
    assign out_col   = r_out_col;
    assign rd_data   = {r_valid, r_overrun, 10'b0, r_key};

    // Next-state logic; the FSM only moves on scan ticks.
    always_comb begin
        w_state_nx = r_state;
        w_col_nx   = r_col;
        w_cnt_nx   = r_cnt;
        w_pat_nx   = r_pat;
        w_idx_nx   = r_row_idx;
        w_latch    = 1'b0;
        if (w_tick) begin
            case (r_state)
                ST_SCAN: begin
                    if (one_cold(r_row_s)) begin
                        w_pat_nx = r_row_s;
                        w_idx_nx = row_index(r_row_s);
                        if (DEB_MAX == CNT_ONE) begin
                            w_latch    = 1'b1;
                            w_cnt_nx   = '0;
                            w_state_nx = ST_PRESSED;
                        end else begin
                            w_cnt_nx   = CNT_ONE;
                            w_state_nx = ST_DEBOUNCE;
                        end
                    end else begin
                        w_col_nx = r_col + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (r_row_s == r_pat) begin
                        if (w_cnt_inc == DEB_MAX) begin
                            w_latch    = 1'b1;
                            w_cnt_nx   = '0;
                            w_state_nx = ST_PRESSED;
                        end else begin
                            w_cnt_nx = w_cnt_inc;
                        end
                    end else begin
                        w_cnt_nx   = '0;
                        w_col_nx   = r_col + 2'd1;
                        w_state_nx = ST_SCAN;
                    end
                end
                ST_PRESSED: begin
                    if (r_row_s == 4'hF) begin
                        if (w_cnt_inc == DEB_MAX) begin
                            w_cnt_nx   = '0;
                            w_col_nx   = r_col + 2'd1;
                            w_state_nx = ST_SCAN;
                        end else begin
                            w_cnt_nx = w_cnt_inc;
                        end
                    end else begin
                        w_cnt_nx = '0;
                    end
                end
                default: begin
                    w_cnt_nx   = '0;
                    w_state_nx = ST_SCAN;
                end
            endcase
        end else begin
            w_latch = 1'b0;
        end
    end

    // State, scan timer, row synchronizer and column drive registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_SCAN;
            r_tick_cnt <= '0;
            r_row_m    <= 4'hF;
            r_row_s    <= 4'hF;
            r_col      <= 2'd0;
            r_out_col  <= 4'b1110;
            r_cnt      <= '0;
            r_pat      <= 4'hF;
            r_row_idx  <= 2'd0;
        end else begin
            r_state    <= w_state_nx;
            r_tick_cnt <= w_tick ? '0 : (r_tick_cnt + TW'(1));
            r_row_m    <= in_row;
            r_row_s    <= r_row_m;
            r_col      <= w_col_nx;
            r_out_col  <= ~(4'b0001 << w_col_nx);
            r_cnt      <= w_cnt_nx;
            r_pat      <= w_pat_nx;
            r_row_idx  <= w_idx_nx;
        end
    end

    // CPU status word; a new key latch takes priority over a coincident read.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_key     <= 4'h0;
        end else if (w_latch) begin
            r_valid   <= 1'b1;
            r_overrun <= re ? 1'b0 : (r_overrun | r_valid);
            r_key     <= {r_col, w_idx_nx};
        end else if (re) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_valid   <= r_valid;
            r_overrun <= r_overrun;
        end
    end

endmodule

// File: tb/tb_keypad_path.sv
// Scoreboard bench for keypad_path: each expected rd_data change is queued by
// the stimulus and popped by a monitor whenever rd_data changes.
module tb_keypad_path;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_row;
    logic [3:0]  out_col;
    logic        re;
    logic [15:0] rd_data;

    logic        key_on;
    logic [1:0]  key_col;
    logic [1:0]  key_row;

    logic [15:0] exp_q[$];
    logic [15:0] mon_prev;
    logic [15:0] exp_v;
    logic        mon_en;
    int          n_total;
    int          n_pass;

    keypad_path #(.SCAN_MOD(4), .DEBOUNCE(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .in_row  (in_row),
        .out_col (out_col),
        .re      (re),
        .rd_data (rd_data)
    );

    always #5 clk = ~clk;

    // Keypad: the pressed switch shorts its row low only while its column is driven.
    assign in_row = (key_on && (out_col[key_col] == 1'b0)) ? ~(4'b0001 << key_row) : 4'hF;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [1:0] c, input logic [1:0] r);
        key_col = c;
        key_row = r;
        key_on  = 1'b1;
    endtask

    // Monitor: every change of rd_data must match the next queued expectation.
    always @(negedge clk) begin
        if (mon_en && (rd_data !== mon_prev)) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL rd_data_event: got %h, required no change", rd_data);
            end else begin
                exp_v = exp_q.pop_front();
                if (rd_data === exp_v) n_pass++;
                else $display("FAIL rd_data_event: got %h, required %h", rd_data, exp_v);
            end
            mon_prev = rd_data;
        end
    end

    initial begin
        logic [3:0] ec;
        logic [3:0] a;
        bit         found;
        n_total = 0;
        n_pass  = 0;
        mon_en  = 1'b0;
        mon_prev = 16'h0000;
        rst = 1'b0;
        re  = 1'b0;
        key_on  = 1'b0;
        key_col = 2'd0;
        key_row = 2'd0;

        // 1: reset values and free-running column scan
        cycles(2);
        check("t1_reset_rd_data", rd_data, 16'h0000);
        check("t1_reset_out_col", {12'h000, out_col}, 16'h000E);
        rst = 1'b1;
        mon_en = 1'b1;
        cycles(2);
        check("t1_scan_col0", {12'h000, out_col}, 16'h000E);
        for (int i = 1; i <= 4; i++) begin
            cycles(4);
            ec = ~(4'b0001 << (i % 4));
            check("t1_scan_step", {12'h000, out_col}, {12'h000, ec});
        end

        // 2: single press col2,row1, one capture, scan resumes after release
        exp_q.push_back(16'h8009);
        press(2'd2, 2'd1);
        cycles(40);
        check("t2_col_held", {12'h000, out_col}, 16'h000B);
        key_on = 1'b0;
        cycles(8);
        check("t2_release_hold", {12'h000, out_col}, 16'h000B);
        cycles(6);
        check("t2_scan_resumed", {12'h000, out_col}, 16'h0007);
        exp_q.push_back(16'h0009);
        re = 1'b1;
        cycles(1);
        re = 1'b0;
        cycles(4);

        // 3: bouncing contact never latches and scanning continues
        press(2'd1, 2'd2);
        for (int i = 0; i < 5; i++) begin
            cycles(4);
            key_on = ~key_on;
        end
        key_on = 1'b0;
        cycles(12);
        check("t3_valid_low", {15'h0000, rd_data[15]}, 16'h0000);
        a = out_col;
        cycles(4);
        check("t3_scan_advance", {12'h000, out_col}, {12'h000, a[2:0], a[3]});

        // 4: two captures without acknowledge set overrun, then re clears both flags
        exp_q.push_back(16'h8009);
        press(2'd2, 2'd1);
        cycles(40);
        key_on = 1'b0;
        cycles(20);
        exp_q.push_back(16'hC003);
        press(2'd0, 2'd3);
        cycles(40);
        key_on = 1'b0;
        cycles(20);
        exp_q.push_back(16'h0003);
        re = 1'b1;
        cycles(1);
        re = 1'b0;
        cycles(4);

        // 5: re coincides with the latch edge of col3,row0 while an old key is pending
        exp_q.push_back(16'h8009);
        press(2'd2, 2'd1);
        cycles(40);
        key_on = 1'b0;
        cycles(20);
        for (int i = 0; i < 8 && out_col == 4'b0111; i++) cycles(1);
        exp_q.push_back(16'h800C);
        press(2'd3, 2'd0);
        found = 1'b0;
        for (int i = 0; i < 24 && !found; i++) begin
            cycles(1);
            if (out_col == 4'b0111) found = 1'b1;
        end
        check("t5_col3_reached", {15'h0000, found}, 16'h0001);
        cycles(11);
        re = 1'b1;
        cycles(1);
        re = 1'b0;
        check("t5_latch_wins", rd_data, 16'h800C);
        check("t5_overrun_clear", {15'h0000, rd_data[14]}, 16'h0000);
        cycles(8);

        // 6: reset while the key is held, then exactly one re-capture
        exp_q.push_back(16'h0000);
        rst = 1'b0;
        cycles(2);
        check("t6_reset_rd_data", rd_data, 16'h0000);
        check("t6_reset_out_col", {12'h000, out_col}, 16'h000E);
        exp_q.push_back(16'h800C);
        rst = 1'b1;
        cycles(60);
        key_on = 1'b0;
        cycles(30);

        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL events_missing: got %0d pending, required 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
